// File: rtl/jt6295_adpcm_pkg.sv
// Shared constants for the multichannel OKI ADPCM decoder.
// Holds the 49-entry step table, the 9-entry attenuation gain table, the
// step-index adjust constants, and small lookup helpers built on them.
package jt6295_adpcm_pkg;

  localparam int unsigned STEP_W   = 11;  // widest step value is 1552
  localparam int unsigned DIFF_W   = 12;  // widest diff is 2910
  localparam int unsigned IDX_W    = 6;
  localparam int unsigned GAIN_W   = 6;   // widest gain is 32
  localparam int unsigned IDX_MAX  = 48;
  localparam int unsigned ATT_MUTE = 9;   // att codes at or above this mute

  // Step index adjustment per nibble magnitude
  localparam int unsigned IDX_DEC   = 1;  // magnitudes 0..3
  localparam int unsigned IDX_INC_4 = 2;
  localparam int unsigned IDX_INC_5 = 4;
  localparam int unsigned IDX_INC_6 = 6;
  localparam int unsigned IDX_INC_7 = 8;

  localparam logic [STEP_W-1:0] STEP_TAB [0:48] = '{
    11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,
    11'd31,   11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,
    11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,   11'd107,
    11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,
    11'd230,  11'd253,  11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
    11'd449,  11'd494,  11'd544,  11'd598,  11'd658,  11'd724,  11'd796,
    11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
  };

  localparam logic [GAIN_W-1:0] GAIN_TAB [0:8] = '{
    6'd32, 6'd22, 6'd16, 6'd11, 6'd8, 6'd6, 6'd4, 6'd3, 6'd2
  };

  // Step size for a step index; idx never exceeds IDX_MAX
  function automatic logic [STEP_W-1:0] step_lut(input logic [IDX_W-1:0] idx);
    return STEP_TAB[idx];
  endfunction

  // Linear gain (x/32) for an attenuation code
  function automatic logic [GAIN_W-1:0] gain_lut(input logic [3:0] att);
    logic [GAIN_W-1:0] g;
    g = '0;
    if (att < 4'(ATT_MUTE)) g = GAIN_TAB[att];
    return g;
  endfunction

  // Next step index, clamped to 0..IDX_MAX
  function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] idx,
                                                input logic [2:0]       mag);
    logic [IDX_W:0] sum;
    sum = {1'b0, idx};
    case (mag)
      3'd4:    sum = sum + (IDX_W+1)'(IDX_INC_4);
      3'd5:    sum = sum + (IDX_W+1)'(IDX_INC_5);
      3'd6:    sum = sum + (IDX_W+1)'(IDX_INC_6);
      3'd7:    sum = sum + (IDX_W+1)'(IDX_INC_7);
      default: sum = (idx == '0) ? '0 : sum - (IDX_W+1)'(IDX_DEC);
    endcase
    if (sum > (IDX_W+1)'(IDX_MAX)) sum = (IDX_W+1)'(IDX_MAX);
    return IDX_W'(sum);
  endfunction

endpackage

// File: rtl/jt6295_adpcm_att.sv
// Channel attenuator: scales a decoded sample by the gain selected by att.
// Ports: pred_i  - signed decoded sample
//        att_i   - attenuation code (0 loudest, 9..15 mute)
//        snd_c_o - (pred_i*gain)>>>5, truncated to SW, combinational
module jt6295_adpcm_att
  import jt6295_adpcm_pkg::*;
#(
  parameter int unsigned SW = 12
) (
  input  logic signed [SW-1:0] pred_i,
  input  logic        [3:0]    att_i,
  output logic signed [SW-1:0] snd_c_o
);

  // |pred|*32 needs SW+5 bits signed; SW+GAIN_W leaves one spare
  localparam int unsigned PW = SW + GAIN_W;

  logic [GAIN_W-1:0]   gain;
  logic signed [PW-1:0] prod;

  assign gain    = gain_lut(att_i);
  assign prod    = PW'(pred_i) * PW'($signed({1'b0, gain}));
  assign snd_c_o = SW'(prod >>> 5);

endmodule

// File: rtl/jt6295_adpcm_mc.sv
// Time-multiplexed OKI ADPCM decoder with per-channel attenuation and mixer.
// One channel slot is serviced per clk with cen=1; ch names the slot whose
// en/data/att are being sampled.
// Ports: clk, rst (sync, active high), cen (slot enable)
//        ch        - current slot channel
//        en/data/att - slot inputs (nibble: bit3 sign, bits2:0 magnitude)
//        snd_ch/snd_id/snd_valid - attenuated sample of the last slot
//        mix/mix_valid           - sum of all channels, once per frame
module jt6295_adpcm_mc
  import jt6295_adpcm_pkg::*;
#(
  parameter  int unsigned CH = 4,
  parameter  int unsigned SW = 12,
  localparam int unsigned CW = (CH > 1) ? $clog2(CH) : 1,
  localparam int unsigned MW = SW + CW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cen,
  output logic [CW-1:0]        ch,
  input  logic                 en,
  input  logic [3:0]           data,
  input  logic [3:0]           att,
  output logic signed [SW-1:0] snd_ch,
  output logic [CW-1:0]        snd_id,
  output logic                 snd_valid,
  output logic signed [MW-1:0] mix,
  output logic                 mix_valid
);

  // Extended width for pred +/- diff before saturation
  localparam int unsigned EW = SW + 6;
  localparam logic signed [EW-1:0] P_MAX = EW'((2 ** (SW - 1)) - 1);
  localparam logic signed [EW-1:0] P_MIN = ~P_MAX;

  logic [CW-1:0]        ch_q, ch_d;
  logic [IDX_W-1:0]     idx_q  [CH];
  logic signed [SW-1:0] pred_q [CH];
  logic [IDX_W-1:0]     idx_d;
  logic signed [SW-1:0] pred_d;
  logic signed [SW-1:0] snd_q, snd_d;
  logic [CW-1:0]        id_q;
  logic                 valid_q, mixv_q;
  logic signed [MW-1:0] acc_q, acc_d, mix_q, mix_d;

  logic [IDX_W-1:0]     idx_cur;
  logic signed [SW-1:0] pred_cur;
  logic [DIFF_W-1:0]    step_w, diff;
  logic signed [EW-1:0] sum_e, diff_e, sat_e;
  logic signed [SW-1:0] att_out;
  logic                 last;
  logic signed [MW-1:0] mix_sum;

  // Slot decode datapath
  assign idx_cur  = idx_q[ch_q];
  assign pred_cur = pred_q[ch_q];
  assign step_w   = DIFF_W'(step_lut(idx_cur));
  assign diff     = (step_w >> 3)
                  + (data[2] ? step_w        : '0)
                  + (data[1] ? (step_w >> 1) : '0)
                  + (data[0] ? (step_w >> 2) : '0);
  assign diff_e   = $signed(EW'(diff));
  assign sum_e    = data[3] ? (EW'(pred_cur) - diff_e) : (EW'(pred_cur) + diff_e);
  assign sat_e    = (sum_e > P_MAX) ? P_MAX : ((sum_e < P_MIN) ? P_MIN : sum_e);
  assign last     = (ch_q == CW'(CH - 1));
  assign mix_sum  = acc_q + MW'(snd_d);

  jt6295_adpcm_att #(.SW(SW)) u_att (
    .pred_i  (pred_d),
    .att_i   (att),
    .snd_c_o (att_out)
  );

  // Next-state for the slot being sampled; a disabled channel restarts from zero
  always_comb begin
    idx_d  = '0;
    pred_d = '0;
    snd_d  = '0;
    ch_d   = ch_q;
    acc_d  = acc_q;
    mix_d  = mix_q;
    if (en) begin
      idx_d  = idx_next(idx_cur, data[2:0]);
      pred_d = SW'(sat_e);
      snd_d  = att_out;
    end
    if (cen) begin
      ch_d = last ? '0 : ch_q + CW'(1);
      if (last) begin
        mix_d = mix_sum;
        acc_d = '0;
      end else begin
        acc_d = mix_sum;
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q    <= '0;
      id_q    <= '0;
      snd_q   <= '0;
      acc_q   <= '0;
      mix_q   <= '0;
      valid_q <= 1'b0;
      mixv_q  <= 1'b0;
      for (int unsigned i = 0; i < CH; i++) begin
        idx_q[i]  <= '0;
        pred_q[i] <= '0;
      end
    end else begin
      valid_q <= cen;
      mixv_q  <= cen & last;
      ch_q    <= ch_d;
      acc_q   <= acc_d;
      mix_q   <= mix_d;
      if (cen) begin
        idx_q[ch_q]  <= idx_d;
        pred_q[ch_q] <= pred_d;
        snd_q        <= snd_d;
        id_q         <= ch_q;
      end
    end
  end

  assign ch        = ch_q;
  assign snd_ch    = snd_q;
  assign snd_id    = id_q;
  assign snd_valid = valid_q;
  assign mix       = mix_q;
  assign mix_valid = mixv_q;

endmodule

// File: tb/tb_jt6295_adpcm_mc.sv
// Bench for jt6295_adpcm_mc (CH=4, SW=12): table of single-channel vectors
// plus sequences for saturation, cen gaps, channel disable and mid-frame reset.
// Expected samples and mixes are queued when a slot is driven and checked
// when the strobes arrive.
module tb_jt6295_adpcm_mc;

  localparam int CH = 4;
  localparam int SW = 12;
  localparam int MW = 14;

  logic                 clk = 1'b0;
  logic                 rst, cen, en;
  logic [3:0]           data, att;
  logic [1:0]           ch, snd_id;
  logic signed [SW-1:0] snd_ch;
  logic                 snd_valid, mix_valid;
  logic signed [MW-1:0] mix;

  always #5 clk = ~clk;

  jt6295_adpcm_mc #(.CH(CH), .SW(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .ch        (ch),
    .en        (en),
    .data      (data),
    .att       (att),
    .snd_ch    (snd_ch),
    .snd_id    (snd_id),
    .snd_valid (snd_valid),
    .mix       (mix),
    .mix_valid (mix_valid)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int step_tab [49] = '{16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45, 50,
                        55, 60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157,
                        173, 190, 209, 230, 253, 279, 307, 337, 371, 408, 449,
                        494, 544, 598, 658, 724, 796, 876, 963, 1060, 1166,
                        1282, 1411, 1552};
  int gain_tab [9] = '{32, 22, 16, 11, 8, 6, 4, 3, 2};

  int m_idx [CH];
  int m_pred [CH];
  int m_ch, m_acc, m_last_snd, m_last_mix;

  typedef struct {
    int snd;
    int id;
  } snd_exp_t;

  snd_exp_t snd_q [$];
  int       mix_q [$];
  snd_exp_t mon_x;
  int       mon_m;

  typedef struct {
    bit         en;
    logic [3:0] data;
    logic [3:0] att;
    int         exp_snd;
  } vec_t;

  vec_t tab [16];

  task automatic check(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_idx[i]  = 0;
      m_pred[i] = 0;
    end
    m_ch = 0; m_acc = 0; m_last_snd = 0; m_last_mix = 0;
  endtask

  // Reference decoder for one slot of channel m_ch
  task automatic model_slot(input bit e, input logic [3:0] d, input logic [3:0] a,
                            output int snd);
    int step, diff, p, mag, g;
    if (!e) begin
      m_idx[m_ch]  = 0;
      m_pred[m_ch] = 0;
      snd = 0;
    end else begin
      step = step_tab[m_idx[m_ch]];
      diff = step / 8;
      if (d[2]) diff += step;
      if (d[1]) diff += step / 2;
      if (d[0]) diff += step / 4;
      p = d[3] ? m_pred[m_ch] - diff : m_pred[m_ch] + diff;
      if (p > 2047) p = 2047;
      if (p < -2048) p = -2048;
      m_pred[m_ch] = p;
      mag = int'(d[2:0]);
      m_idx[m_ch] += (mag < 4) ? -1 : 2 * (mag - 3);
      if (m_idx[m_ch] < 0) m_idx[m_ch] = 0;
      if (m_idx[m_ch] > 48) m_idx[m_ch] = 48;
      g = (a >= 4'd9) ? 0 : gain_tab[a];
      snd = (p * g) >>> 5;
    end
  endtask

  // Drive one cen slot; force_exp replaces the model's sample with exp_v
  task automatic drive_slot(input bit e, input logic [3:0] d, input logic [3:0] a,
                            input bit force_exp, input int exp_v);
    int snd;
    snd_exp_t x;
    check("ch_before_slot", int'(ch), m_ch);
    model_slot(e, d, a, snd);
    if (force_exp) snd = exp_v;
    x.snd = snd;
    x.id  = m_ch;
    snd_q.push_back(x);
    m_last_snd = snd;
    m_acc += snd;
    if (m_ch == CH - 1) begin
      mix_q.push_back(m_acc);
      m_last_mix = m_acc;
      m_acc = 0;
    end
    m_ch = (m_ch + 1) % CH;
    cen = 1'b1; en = e; data = d; att = a;
    @(posedge clk);
    #1 cen = 1'b0;
  endtask

  task automatic gap(input int n);
    cen = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      check("gap_snd_valid", int'(snd_valid), 0);
      check("gap_mix_valid", int'(mix_valid), 0);
      check("gap_snd_hold", int'(snd_ch), m_last_snd);
      check("gap_mix_hold", int'(mix), m_last_mix);
      check("gap_ch_hold", int'(ch), m_ch);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ch", int'(ch), 0);
    check("rst_snd_id", int'(snd_id), 0);
    check("rst_snd_ch", int'(snd_ch), 0);
    check("rst_mix", int'(mix), 0);
    check("rst_snd_valid", int'(snd_valid), 0);
    check("rst_mix_valid", int'(mix_valid), 0);
    rst = 1'b0;
    model_reset();
  endtask

  // Scoreboard: pop an expectation per strobe
  always @(negedge clk) begin
    if (snd_valid) begin
      if (snd_q.size() == 0) begin
        check("snd_valid_unexpected", 1, 0);
      end else begin
        mon_x = snd_q.pop_front();
        check("snd_ch", int'(snd_ch), mon_x.snd);
        check("snd_id", int'(snd_id), mon_x.id);
      end
    end
    if (mix_valid) begin
      check("mix_valid_with_snd_valid", int'(snd_valid), 1);
      if (mix_q.size() == 0) begin
        check("mix_valid_unexpected", 1, 0);
      end else begin
        mon_m = mix_q.pop_front();
        check("mix", int'(mix), mon_m);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ch0 vectors; ch1..3 idle each frame. Expected values hand-derived.
    tab[0]  = '{1'b1, 4'h7, 4'h0, 30};   // idx0 -> pred 30, idx 8
    tab[1]  = '{1'b0, 4'h0, 4'h0, 0};    // disable clears state
    tab[2]  = '{1'b1, 4'h7, 4'h2, 15};   // pred 30, gain 16
    tab[3]  = '{1'b1, 4'h0, 4'h9, 0};    // pred 34 muted, idx 7
    tab[4]  = '{1'b1, 4'h0, 4'h0, 37};   // pred kept updating under mute
    tab[5]  = '{1'b1, 4'hF, 4'h0, -15};  // 37 - 52
    tab[6]  = '{1'b0, 4'h0, 4'h0, 0};
    tab[7]  = '{1'b1, 4'hF, 4'h0, -30};  // negative from cleared state
    tab[8]  = '{1'b0, 4'h0, 4'h0, 0};
    tab[9]  = '{1'b1, 4'h0, 4'h0, 2};    // idx 0 stays 0
    tab[10] = '{1'b1, 4'h0, 4'h0, 4};    // proves idx stayed 0
    tab[11] = '{1'b1, 4'h0, 4'h4, 1};    // 6*8>>5
    tab[12] = '{1'b0, 4'h0, 4'h0, 0};
    tab[13] = '{1'b1, 4'hF, 4'h1, -21};  // -660>>>5 floors
    tab[14] = '{1'b1, 4'h0, 4'hF, 0};    // pred -26, muted
    tab[15] = '{1'b1, 4'h0, 4'h3, -8};   // -23*11 = -253 >>> 5

    rst = 1'b1; cen = 1'b0; en = 1'b0; data = 4'h0; att = 4'h0;
    model_reset();
    @(posedge clk);
    do_reset();

    for (int i = 0; i < 16; i++) begin
      drive_slot(tab[i].en, tab[i].data, tab[i].att, 1'b1, tab[i].exp_snd);
      for (int k = 1; k < CH; k++) drive_slot(1'b0, 4'h0, 4'h0, 1'b0, 0);
    end

    // Predictor and index saturation
    do_reset();
    for (int f = 0; f < 30; f++) begin
      drive_slot(1'b1, 4'h7, 4'h0, f == 29, 2047);
      for (int k = 1; k < CH; k++) drive_slot(1'b0, 4'h0, 4'h0, 1'b0, 0);
    end
    drive_slot(1'b1, 4'hF, 4'h0, 1'b1, -863);  // idx 48: 2047 - 2910
    for (int k = 1; k < CH; k++) drive_slot(1'b0, 4'h0, 4'h0, 1'b0, 0);

    // All channels active with cen gaps
    do_reset();
    drive_slot(1'b1, 4'h7, 4'h0, 1'b1, 30);
    gap(3);
    drive_slot(1'b1, 4'h7, 4'h0, 1'b1, 30);
    drive_slot(1'b1, 4'h7, 4'h0, 1'b1, 30);
    gap(2);
    drive_slot(1'b1, 4'h7, 4'h0, 1'b1, 30);
    gap(2);
    check("mix_four_channels", int'(mix), 120);

    // ch2 disabled mid-stream then re-enabled
    for (int k = 0; k < CH; k++) drive_slot(1'b1, 4'h7, 4'h0, 1'b0, 0);
    for (int k = 0; k < CH; k++) drive_slot(k != 2, 4'h7, 4'h0, k == 2, 0);
    for (int k = 0; k < CH; k++) drive_slot(1'b1, 4'h7, 4'h0, k == 2, 30);

    // Reset mid-frame discards the partial sum
    drive_slot(1'b1, 4'h7, 4'h0, 1'b0, 0);
    drive_slot(1'b1, 4'h7, 4'h0, 1'b0, 0);
    do_reset();
    for (int k = 0; k < CH; k++) drive_slot(1'b1, 4'h7, 4'h0, 1'b1, 30);
    gap(1);
    check("mix_after_midframe_reset", int'(mix), 120);

    repeat (2) @(posedge clk);
    check("snd_queue_drained", snd_q.size(), 0);
    check("mix_queue_drained", mix_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
